sw_popcount_debounce: RTL and testbench



---
 rtl/sw_pkg.sv | 18 +
 rtl/sw_debounce_ch.sv | 51 +++++
 rtl/sw_popcount_debounce.sv | 85 ++++++++
 tb/tb_sw_popcount_debounce.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared constants and helpers for the switch popcount/debounce block.
package sw_pkg;

  // Level of a switch that is not pressed (the pins are active-low)
  localparam logic SW_RELEASED = 1'b1;

  // Default debounce window in clock cycles
  localparam int DEB_DEFAULT = 250000;

  // Number of bits needed to hold every value from 0 to n (at least 1)
  function automatic int clog2_cnt(input int n);
    for (int w = 1; w < 32; w++) begin
      if ((64'd1 << w) > 64'(n)) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: two-flop synchroniser followed by a stable-level
// debouncer. A new level is accepted only after DEB_CYCLES consecutive
// cycles that differ from the current stable level.
module sw_debounce_ch
  import sw_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_DEFAULT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SW_RAW,
  output logic PRESSED
);

  localparam int CNT_W = clog2_cnt(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_st;
  logic [CNT_W-1:0] r_cnt;

  // Bring the asynchronous pin into the clock domain
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= SW_RELEASED;
      r_sync2 <= SW_RELEASED;
    end else begin
      r_sync1 <= SW_RAW;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive differing cycles; any return to the stable level restarts
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_st  <= SW_RELEASED;
      r_cnt <= '0;
    end else if (r_sync2 == r_st) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_st  <= r_sync2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign PRESSED = ~r_st;

endmodule

// File: rtl/sw_popcount_debounce.sv
// Counts debounced pressed switches and drives the count to LEDs.
// Optional peak-hold output enabled by defining SW_PEAK_HOLD_EN.
module sw_popcount_debounce
  import sw_pkg::*;
#(
  parameter int            N_SW         = 3,
  parameter int            DEB_CYCLES   = DEB_DEFAULT,
  parameter int            CW           = clog2_cnt(N_SW),
  parameter logic [CW-1:0] LED_INV_MASK = {CW{1'b0}}
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N_SW-1:0] SW,
  output logic [CW-1:0]   COUNT,
  output logic [CW-1:0]   LED,
  output logic            CHANGE,
  output logic [N_SW-1:0] PRESSED
`ifdef SW_PEAK_HOLD_EN
  ,
  input  logic            PEAK_CLR,
  output logic [CW-1:0]   PEAK
`endif
);

  logic [N_SW-1:0] w_pressed;
  logic [CW-1:0]   w_pop;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_led;
  logic            r_change;

  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    sw_debounce_ch #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_ch (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .SW_RAW (SW[i]),
      .PRESSED(w_pressed[i])
    );
  end

  // Population count of the debounced pressed vector
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_SW; i++) begin
      w_pop = w_pop + CW'(w_pressed[i]);
    end
  end

  // Registered count, LED image and change strobe, all loaded together
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_count  <= '0;
      r_led    <= LED_INV_MASK;
      r_change <= 1'b0;
    end else begin
      r_count  <= w_pop;
      r_led    <= w_pop ^ LED_INV_MASK;
      r_change <= (w_pop != r_count);
    end
  end

`ifdef SW_PEAK_HOLD_EN
  logic [CW-1:0] r_peak;

  // Track the highest count seen; a clear reloads from the current count
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_peak <= '0;
    end else if (PEAK_CLR) begin
      r_peak <= w_pop;
    end else if (w_pop > r_peak) begin
      r_peak <= w_pop;
    end
  end

  assign PEAK = r_peak;
`endif

  assign COUNT   = r_count;
  assign LED     = r_led;
  assign CHANGE  = r_change;
  assign PRESSED = w_pressed;

endmodule

// File: tb/tb_sw_popcount_debounce.sv
module tb_sw_popcount_debounce;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [2:0] SW = 3'b000;
  logic [1:0] COUNT;
  logic [1:0] LED;
  logic       CHANGE;
  logic [2:0] PRESSED;
`ifdef SW_PEAK_HOLD_EN
  logic       PEAK_CLR = 1'b0;
  logic [1:0] PEAK;
`endif

  sw_popcount_debounce #(
    .N_SW        (3),
    .DEB_CYCLES  (4),
    .LED_INV_MASK(2'b01)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .SW     (SW),
    .COUNT  (COUNT),
    .LED    (LED),
    .CHANGE (CHANGE),
    .PRESSED(PRESSED)
`ifdef SW_PEAK_HOLD_EN
    ,
    .PEAK_CLR(PEAK_CLR),
    .PEAK    (PEAK)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int cnt;
    int led;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected CHANGE event: count/led due 7 cycles after a pin edge at this cycle
  task automatic push(input int cnt, input int led);
    exp_t e;
    e.cyc = cyc + 7;
    e.cnt = cnt;
    e.led = led;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Monitor: every CHANGE pulse must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0 && cyc > q[0].cyc) begin
        e = q.pop_front();
        chk("change_missing_at_cycle", cyc, e.cyc);
      end
      if (CHANGE) begin
        if (q.size() == 0) begin
          chk("unexpected_change", int'(CHANGE), 0);
        end else begin
          e = q.pop_front();
          chk("change_cycle", cyc, e.cyc);
          chk("change_count", int'(COUNT), e.cnt);
          chk("change_led", int'(LED), e.led);
        end
      end
    end
  end

  initial begin
    int c_rel;

    // Reset with all switches held pressed
    wait_cyc(3);
    #1;
    chk("rst_count", int'(COUNT), 0);
    chk("rst_led", int'(LED), 1);
    chk("rst_pressed", int'(PRESSED), 0);
    chk("rst_change", int'(CHANGE), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    push(3, 2);
    wait_cyc(12);

    // Short glitches on SW[0] must never be accepted
    RST_N = 1'b0;
    SW = 3'b111;
    wait_cyc(2);
    RST_N = 1'b1;
    wait_cyc(5);
    for (int k = 0; k < 5; k++) begin
      SW = 3'b110;
      wait_cyc(3);
      SW = 3'b111;
      wait_cyc(3);
    end
    wait_cyc(6);
    chk("glitch_pressed", int'(PRESSED), 0);
    chk("glitch_count", int'(COUNT), 0);

    // Stepping up one switch at a time
    SW = 3'b110; push(1, 0); wait_cyc(10);
    SW = 3'b100; push(2, 3); wait_cyc(10);
    SW = 3'b000; push(3, 2); wait_cyc(10);
    chk("step_count", int'(COUNT), 3);

    // Two channels release together: one update, one pulse
    SW = 3'b110; push(1, 0); wait_cyc(10);
    chk("sim_pressed_before", int'(PRESSED), 1);
`ifdef SW_PEAK_HOLD_EN
    chk("peak_hold", int'(PEAK), 3);
    PEAK_CLR = 1'b1;
    @(posedge CLK);
    #1;
    chk("peak_clr", int'(PEAK), 1);
    @(negedge CLK);
    PEAK_CLR = 1'b0;
`endif
    // Press one and release another in the same cycle: no count change
    SW = 3'b101;
    wait_cyc(10);
    chk("sim_pressed_after", int'(PRESSED), 2);
    chk("sim_count", int'(COUNT), 1);

    // Reset in the middle of a debounce window
    RST_N = 1'b0;
    SW = 3'b111;
    wait_cyc(2);
    RST_N = 1'b1;
    wait_cyc(4);
    SW = 3'b101;
    wait_cyc(2);
    RST_N = 1'b0;
    #1;
    chk("midrst_count_during", int'(COUNT), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    c_rel = cyc;
    push(1, 0);
    #1;
    chk("midrst_count_after", int'(COUNT), 0);
    wait_cyc(5);
    chk("midrst_count_early", int'(COUNT), 0);
    wait_cyc(6);
    chk("midrst_pressed", int'(PRESSED), 2);
    chk("midrst_count", int'(COUNT), 1);
    chk("midrst_elapsed_ok", int'(cyc - c_rel >= 7), 1);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge CLK);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
